gcd_feeder: RTL

//  Initiator side of the gcd_thread operand protocol. Accepts (a,b) jobs on a valid/ready

---
 rtl/gcd_pkg.sv | 34 +++
 rtl/gcd_cmd_fifo.sv | 73 +++++++
 rtl/gcd_feeder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gcd_pkg
// Purpose : Shared definitions for the gcd_thread initiator (gcd_feeder) and
//           the benches around gcd_thread: default operand width and the
//           3-bit encodings of the feeder FSM states.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package gcd_pkg;

   // Default operand/result width. Must match the attached gcd_thread.
   localparam int c_DATA_W = 8;

   // Feeder FSM state encodings.
   localparam int c_ST_W = 3;
   localparam logic [c_ST_W-1:0] c_ST_IDLE = 3'd0;
   localparam logic [c_ST_W-1:0] c_ST_LOAD = 3'd1;
   localparam logic [c_ST_W-1:0] c_ST_OPA  = 3'd2;
   localparam logic [c_ST_W-1:0] c_ST_OPB  = 3'd3;
   localparam logic [c_ST_W-1:0] c_ST_WAIT = 3'd4;
   localparam logic [c_ST_W-1:0] c_ST_RESP = 3'd5;

   typedef enum logic [c_ST_W-1:0] {
      ST_IDLE = c_ST_IDLE,
      ST_LOAD = c_ST_LOAD,
      ST_OPA  = c_ST_OPA,
      ST_OPB  = c_ST_OPB,
      ST_WAIT = c_ST_WAIT,
      ST_RESP = c_ST_RESP
   } gcd_state_t;

endpackage
`default_nettype wire

// File: rtl/gcd_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module  : gcd_cmd_fifo
// Purpose : Synchronous command FIFO holding packed {a,b} jobs for the feeder.
//           No empty-bypass: a word pushed into an empty FIFO becomes visible
//           on o_data the cycle after the push.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           i_push/i_data - write strobe and word (ignored when full)
//           i_pop         - remove the head word (ignored when empty)
//           o_data        - head word (valid while !o_empty)
//           o_full/o_empty- occupancy flags derived from a DEPTH+1 range count
// Revision: 1.0 - initial release
// ============================================================================
module gcd_cmd_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4     // power of 2, >= 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int             c_AW   = $clog2(DEPTH);
   localparam logic [c_AW:0]  c_FULL = (c_AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop  & ~o_empty;
   assign o_full  = (r_count == c_FULL);
   assign o_empty = (r_count == '0);
   assign o_data  = r_mem[r_rd_ptr];

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of 2.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/gcd_feeder.sv
`default_nettype none
// ============================================================================
// Module  : gcd_feeder
// Purpose : Initiator for one gcd_thread. Buffers (a,b) jobs from a
//           valid/ready command port, serialises each onto the thread's
//           load/val bus (load, a, b), waits for done under a watchdog and
//           returns the result on a valid/ready response port.
// Ports   : clk, rst                          - clock, sync active-high reset
//           cmd_valid/cmd_ready/cmd_a/cmd_b   - job input
//           rsp_valid/rsp_ready/rsp_gcd/
//           rsp_timeout                       - result output (held until taken)
//           thr_rst/thr_load/thr_val          - drive to gcd_thread
//           thr_done/thr_result               - return from gcd_thread
//           busy                              - job in flight or queued
// Revision: 1.0 - initial release
// ============================================================================
module gcd_feeder
   import gcd_pkg::*;
#(
   parameter int DATA_W     = c_DATA_W,
   parameter int FIFO_DEPTH = 4,    // power of 2, >= 2
   parameter int TIMEOUT    = 32    // >= 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_gcd,
   output logic              rsp_timeout,
   output logic              thr_rst,
   output logic              thr_load,
   output logic [DATA_W-1:0] thr_val,
   input  logic              thr_done,
   input  logic [DATA_W-1:0] thr_result,
   output logic              busy
);

   localparam int                 c_WDOG_W    = $clog2(TIMEOUT) + 1;
   localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(TIMEOUT - 1);

   gcd_state_t          r_state;
   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;
   logic [c_WDOG_W-1:0] r_wdog;
   logic                r_rsp_valid;
   logic                r_rsp_timeout;
   logic [DATA_W-1:0]   r_rsp_gcd;
   logic                r_thr_rst;
   logic                r_thr_load;
   logic [DATA_W-1:0]   r_thr_val;

   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic [2*DATA_W-1:0] w_head;

   // Not ready while in reset so nothing is accepted into a FIFO being cleared.
   assign cmd_ready = ~w_full & ~rst;
   assign w_push    = cmd_valid & cmd_ready;
   assign w_pop     = (r_state == ST_IDLE) & ~w_empty;
   assign busy      = (r_state != ST_IDLE) | ~w_empty;

   assign rsp_valid   = r_rsp_valid;
   assign rsp_timeout = r_rsp_timeout;
   assign rsp_gcd     = r_rsp_gcd;
   assign thr_rst     = r_thr_rst;
   assign thr_load    = r_thr_load;
   assign thr_val     = r_thr_val;

   gcd_cmd_fifo #(
      .WIDTH (2*DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  ({cmd_a, cmd_b}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Each output is set on the transition into the state that presents it,
   // so the bus shows load / a / b in the LOAD / OPA / OPB cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_a           <= '0;
         r_b           <= '0;
         r_wdog        <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_timeout <= 1'b0;
         r_rsp_gcd     <= '0;
         r_thr_rst     <= 1'b1;
         r_thr_load    <= 1'b0;
         r_thr_val     <= '0;
      end else begin
         r_thr_rst <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  {r_a, r_b} <= w_head;
                  r_thr_load <= 1'b1;
                  r_thr_val  <= '0;
                  r_state    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               r_thr_load <= 1'b0;
               r_thr_val  <= r_a;
               r_state    <= ST_OPA;
            end
            ST_OPA: begin
               r_thr_val <= r_b;
               r_state   <= ST_OPB;
            end
            ST_OPB: begin
               r_thr_val <= '0;
               r_wdog    <= '0;
               r_state   <= ST_WAIT;
            end
            ST_WAIT: begin
               if (thr_done) begin
                  r_rsp_gcd     <= thr_result;
                  r_rsp_timeout <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_state       <= ST_RESP;
               end else if (r_wdog == c_WDOG_LAST) begin
                  // Abort: restart the thread so a late done cannot leak
                  // into the next job.
                  r_rsp_gcd     <= '0;
                  r_rsp_timeout <= 1'b1;
                  r_rsp_valid   <= 1'b1;
                  r_thr_rst     <= 1'b1;
                  r_state       <= ST_RESP;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
